// File: rtl/mac_row_feeder_pkg.sv
// mac_row_feeder shared types.
// FSM state encoding and row instruction codes.
package mac_row_feeder_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_EXEC,
    S_DRAIN
  } state_t;

  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/mac_row_feeder.sv
// Feeds one MAC row: loads a kernel of col weights once,
// then streams activations with registered data/instruction.
module mac_row_feeder #(
  parameter int bw     = 4,
  parameter int col    = 8,
  parameter int cnt_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [cnt_bw-1:0] num_act,
  input  logic [bw-1:0]     w_data,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [bw-1:0]     a_data,
  input  logic              a_valid,
  output logic              a_ready,
  output logic [bw-1:0]     out_w,
  output logic [1:0]        inst_w,
  output logic              busy,
  output logic              loaded,
  output logic              done
);

  import mac_row_feeder_pkg::*;

  localparam int CW = $clog2(col) + 1;
  localparam logic [CW-1:0] LAST = CW'(col - 1);
  localparam logic [CW-1:0] ONE_W = 1;
  localparam logic [cnt_bw-1:0] ONE_A = 1;

  state_t r_state, w_state_nxt;

  logic [CW-1:0]     r_wcnt, w_wcnt_nxt;
  logic [CW-1:0]     r_dcnt, w_dcnt_nxt;
  logic [cnt_bw-1:0] r_acnt, w_acnt_nxt;
  logic [cnt_bw-1:0] r_num, w_num_nxt;
  logic [cnt_bw-1:0] w_acnt_inc;
  logic              r_loaded, w_loaded_nxt;
  logic [bw-1:0]     r_out, w_out_nxt;
  logic [1:0]        r_inst, w_inst_nxt;

  assign w_acnt_inc = r_acnt + ONE_A;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wcnt   <= '0;
      r_dcnt   <= '0;
      r_acnt   <= '0;
      r_num    <= '0;
      r_loaded <= 1'b0;
      r_out    <= '0;
      r_inst   <= INST_NOP;
    end else begin
      r_wcnt   <= w_wcnt_nxt;
      r_dcnt   <= w_dcnt_nxt;
      r_acnt   <= w_acnt_nxt;
      r_num    <= w_num_nxt;
      r_loaded <= w_loaded_nxt;
      r_out    <= w_out_nxt;
      r_inst   <= w_inst_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wcnt_nxt   = r_wcnt;
    w_dcnt_nxt   = r_dcnt;
    w_acnt_nxt   = r_acnt;
    w_num_nxt    = r_num;
    w_loaded_nxt = r_loaded;
    w_out_nxt    = r_out;
    w_inst_nxt   = INST_NOP;
    w_ready      = 1'b0;
    a_ready      = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_num_nxt   = num_act;
          w_acnt_nxt  = '0;
          w_wcnt_nxt  = '0;
          w_dcnt_nxt  = '0;
          w_state_nxt = r_loaded ? S_EXEC : S_LOAD;
        end
      end
      S_LOAD: begin
        w_ready = 1'b1;
        if (w_valid) begin
          w_out_nxt  = w_data;
          w_inst_nxt = INST_LOAD;
          w_wcnt_nxt = r_wcnt + ONE_W;
          if (r_wcnt == LAST) begin
            w_loaded_nxt = 1'b1;
            w_state_nxt  = S_GAP;
          end
        end
      end
      S_GAP: begin
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        // num_act of zero falls straight through to DRAIN
        if (r_acnt == r_num) begin
          w_state_nxt = S_DRAIN;
        end else begin
          a_ready = 1'b1;
          if (a_valid) begin
            w_out_nxt  = a_data;
            w_inst_nxt = INST_EXEC;
            w_acnt_nxt = w_acnt_inc;
            if (w_acnt_inc == r_num) begin
              w_state_nxt = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        w_dcnt_nxt = r_dcnt + ONE_W;
        if (r_dcnt == LAST) begin
          done        = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign out_w  = r_out;
  assign inst_w = r_inst;
  assign busy   = (r_state != S_IDLE);
  assign loaded = r_loaded;

endmodule

// File: tb/tb_mac_row_feeder.sv
// Bench for mac_row_feeder: directed pass scenarios plus
// randomized passes scored against a transaction-level model.
module tb_mac_row_feeder;

  localparam int BW  = 4;
  localparam int COL = 8;
  localparam int CBW = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [CBW-1:0] num_act = '0;
  logic [BW-1:0]  w_data = '0;
  logic           w_valid = 1'b0;
  logic           w_ready;
  logic [BW-1:0]  a_data = '0;
  logic           a_valid = 1'b0;
  logic           a_ready;
  logic [BW-1:0]  out_w;
  logic [1:0]     inst_w;
  logic           busy;
  logic           loaded;
  logic           done;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_row_feeder #(
    .bw(BW),
    .col(COL),
    .cnt_bw(CBW)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .num_act(num_act),
    .w_data(w_data),
    .w_valid(w_valid),
    .w_ready(w_ready),
    .a_data(a_data),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .out_w(out_w),
    .inst_w(inst_w),
    .busy(busy),
    .loaded(loaded),
    .done(done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    w_valid = 1'b0;
    a_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("inst_not11", 32'(inst_w == 2'b11), 0);
      chk("exec_needs_load",
          32'((inst_w == 2'b10) && !loaded), 0);
    end
  end

  // Each accepted word must come out next cycle, in order;
  // done lands col cycles after the last activation.
  task automatic run_pass(input int num,
                          input bit need_load,
                          input int pv);
    int c;
    int wacc;
    int aacc;
    int lastw;
    int lasta;
    int donec;
    int expd;
    bit pend;
    logic [1:0] pi;
    logic [BW-1:0] pd;
    wacc = 0;
    aacc = 0;
    lastw = -1;
    lasta = -1;
    donec = -1;
    pend = 1'b0;
    pi = 2'b00;
    pd = '0;
    start = 1'b1;
    num_act = CBW'(num);
    for (c = 0; c < 3000; c++) begin
      if (c > 0) begin
        if (pend) begin
          chk("rp_inst", 32'(inst_w), 32'(pi));
          chk("rp_out", 32'(out_w), 32'(pd));
        end else begin
          chk("rp_nop", 32'(inst_w), 0);
        end
        pend = 1'b0;
        if (c == 1) chk("rp_wready1", 32'(w_ready), 32'(need_load));
        if (!need_load) chk("rp_wready0", 32'(w_ready), 0);
        if (need_load && wacc < COL) chk("rp_aready0", 32'(a_ready), 0);
        if (done) begin
          donec = c;
          break;
        end
        start = ($urandom % 10) == 0;
        num_act = CBW'($urandom);
      end
      w_valid = ($urandom % 100) < pv;
      w_data = BW'($urandom);
      a_valid = ($urandom % 100) < pv;
      a_data = BW'($urandom);
      if (w_valid && w_ready) begin
        pend = 1'b1;
        pi = 2'b01;
        pd = w_data;
        wacc++;
        lastw = c;
      end
      if (a_valid && a_ready) begin
        pend = 1'b1;
        pi = 2'b10;
        pd = a_data;
        aacc++;
        lasta = c;
      end
      tick();
    end
    start = 1'b0;
    w_valid = 1'b0;
    a_valid = 1'b0;
    if (num == 0) expd = (need_load ? lastw + 1 : 0) + 1 + COL;
    else expd = lasta + COL;
    chk("rp_done_cycle", donec, expd);
    chk("rp_wacc", wacc, need_load ? COL : 0);
    chk("rp_aacc", aacc, num);
    tick();
    chk("rp_idle_busy", 32'(busy), 0);
    chk("rp_done_once", 32'(done), 0);
  endtask

  initial begin
    int donec;
    bit saw10;

    reset = 1'b0;
    w_valid = 1'b1;
    a_valid = 1'b1;
    tick();
    chk("rst_inst", 32'(inst_w), 0);
    chk("rst_out", 32'(out_w), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_loaded", 32'(loaded), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wready", 32'(w_ready), 0);
    chk("rst_aready", 32'(a_ready), 0);
    w_valid = 1'b0;
    a_valid = 1'b0;
    reset = 1'b1;
    tick();

    // fresh load then throttled exec
    start = 1'b1;
    num_act = 8'd3;
    tick();
    start = 1'b0;
    chk("l_busy", 32'(busy), 1);
    for (int k = 1; k <= COL; k++) begin
      chk("l_wready", 32'(w_ready), 1);
      chk("l_aready", 32'(a_ready), 0);
      w_valid = 1'b1;
      w_data = BW'(k);
      a_valid = 1'b1;
      a_data = 4'hf;
      tick();
      chk("l_out", 32'(out_w), k);
      chk("l_inst", 32'(inst_w), 1);
    end
    w_valid = 1'b0;
    chk("l_loaded", 32'(loaded), 1);
    chk("gap_wready", 32'(w_ready), 0);
    chk("gap_aready", 32'(a_ready), 0);
    tick();
    chk("gap_inst", 32'(inst_w), 0);
    chk("x_aready", 32'(a_ready), 1);
    a_data = 4'd5;
    tick();
    chk("x_inst0", 32'(inst_w), 2);
    chk("x_out0", 32'(out_w), 5);
    a_valid = 1'b0;
    tick();
    chk("x_inst1", 32'(inst_w), 0);
    a_valid = 1'b1;
    a_data = 4'd6;
    tick();
    chk("x_inst2", 32'(inst_w), 2);
    chk("x_out2", 32'(out_w), 6);
    a_data = 4'd7;
    tick();
    chk("x_inst3", 32'(inst_w), 2);
    chk("x_out3", 32'(out_w), 7);
    a_valid = 1'b0;
    for (int i = 0; i < COL; i++) begin
      chk("d_done", 32'(done), 32'(i == COL - 1));
      chk("d_busy", 32'(busy), 1);
      tick();
      chk("d_inst", 32'(inst_w), 0);
    end
    chk("d_busy_fall", 32'(busy), 0);
    chk("d_done_fall", 32'(done), 0);

    // second pass skips LOAD
    start = 1'b1;
    num_act = 8'd2;
    tick();
    start = 1'b0;
    chk("p2_wready", 32'(w_ready), 0);
    chk("p2_aready", 32'(a_ready), 1);
    chk("p2_inst_c1", 32'(inst_w), 0);
    a_valid = 1'b1;
    a_data = 4'd3;
    tick();
    chk("p2_inst_c2", 32'(inst_w), 2);
    chk("p2_out_c2", 32'(out_w), 3);
    a_data = 4'd12;
    tick();
    chk("p2_inst_c3", 32'(inst_w), 2);
    chk("p2_out_c3", 32'(out_w), 12);
    chk("p2_aready_end", 32'(a_ready), 0);
    a_valid = 1'b0;
    for (int i = 0; i < COL; i++) begin
      chk("p2_done", 32'(done), 32'(i == COL - 1));
      tick();
    end
    chk("p2_idle", 32'(busy), 0);

    // zero activations
    start = 1'b1;
    num_act = 8'd0;
    a_valid = 1'b1;
    a_data = 4'd9;
    donec = -1;
    saw10 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = 1'b0;
      if (inst_w == 2'b10) saw10 = 1'b1;
      if (done) begin
        donec = c;
        break;
      end
    end
    a_valid = 1'b0;
    chk("z_done_cycle", donec, 9);
    chk("z_no_exec", 32'(saw10), 0);
    tick();
    chk("z_idle", 32'(busy), 0);

    // reset in the middle of a load
    do_reset();
    tick();
    start = 1'b1;
    num_act = 8'd5;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_valid = 1'b1;
      w_data = BW'(k + 9);
      tick();
    end
    chk("mr_pre_inst", 32'(inst_w), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_inst", 32'(inst_w), 0);
    chk("mr_loaded", 32'(loaded), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_wready", 32'(w_ready), 0);
    w_valid = 1'b0;
    tick();
    reset = 1'b1;
    donec = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done) donec++;
    end
    chk("mr_no_done", donec, 0);
    chk("mr_idle", 32'(busy), 0);
    run_pass($urandom_range(1, 6), 1'b1, 80);

    for (int i = 0; i < 6; i++) begin
      run_pass($urandom_range(0, 12), 1'b0, $urandom_range(30, 100));
    end
    do_reset();
    tick();
    run_pass($urandom_range(0, 10), 1'b1, 50);
    run_pass(0, 1'b0, 60);
    run_pass(15, 1'b0, 40);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
